bridge_master_port: RTL

- Local-side entry of the inter-group bus bridge, upstream of the slave-side bridge in the other group.
- Acts as a slave on the local bus for addresses with bit 15 set.
- Forwards each accepted request (address, write data, mode) to the other group and waits for the response. Returns read data or a write acknowledge to the local master.
- Handles one outstanding transaction at a time, with a response timeout that produces an error response.

---
 rtl/bridge_master_port.sv | 124 ++++++++++++
 1 files changed

// File: rtl/bridge_master_port.sv
// Local-side master port of the inter-group bus bridge: forwards one request at a time to the
// remote group and returns its read data, write ack or a timeout error to the local master.
module bridge_master_port #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [15:0] lb_addr,
    input  logic [7:0]  lb_wdata,
    input  logic        lb_mode,
    input  logic        lb_valid,
    output logic        lb_ready,
    output logic [7:0]  lb_rdata,
    output logic        lb_rvalid,
    output logic        lb_err,
    output logic [15:0] address_out,
    output logic [7:0]  data_out,
    output logic        mode_out,
    output logic        valid_out,
    input  logic        remote_ready,
    input  logic [7:0]  data_in,
    input  logic        valid_in
);

    typedef enum logic [1:0] {StIdle, StSend, StWait, StResp} state_t;

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] addr_q, addr_d;
    logic [7:0]  wdata_q, wdata_d;
    logic        mode_q, mode_d;
    logic [7:0]  rdata_q, rdata_d;
    logic        err_q, err_d;
    logic        resp_hit;
    logic        expire;

    assign expire = (cnt_q == 16'(TIMEOUT - 1));

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        mode_d   = mode_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        resp_hit = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (lb_valid) begin
                    // Remote side sees a plain local address: the group-select bit is stripped.
                    addr_d  = lb_addr & 16'h7FFF;
                    wdata_d = lb_wdata;
                    mode_d  = lb_mode;
                    cnt_d   = '0;
                    state_d = StSend;
                end
            end
            StSend: begin
                cnt_d = cnt_q + 16'd1;
                if (remote_ready && valid_in) begin
                    resp_hit = 1'b1;
                end else if (expire) begin
                    state_d = StResp;
                    rdata_d = 8'hFF;
                    err_d   = 1'b1;
                end else if (remote_ready) begin
                    state_d = StWait;
                end
            end
            StWait: begin
                cnt_d = cnt_q + 16'd1;
                if (valid_in) begin
                    resp_hit = 1'b1;
                end else if (expire) begin
                    state_d = StResp;
                    rdata_d = 8'hFF;
                    err_d   = 1'b1;
                end
            end
            StResp: begin
                state_d = StIdle;
            end
        endcase

        // A real response always beats a simultaneous expiry.
        if (resp_hit) begin
            state_d = StResp;
            rdata_d = mode_q ? 8'h00 : data_in;
            err_d   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            mode_q  <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            mode_q  <= mode_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign lb_ready    = (state_q == StIdle);
    assign lb_rvalid   = (state_q == StResp);
    assign valid_out   = (state_q == StSend);
    assign lb_rdata    = rdata_q;
    assign lb_err      = err_q;
    assign address_out = addr_q;
    assign data_out    = wdata_q;
    assign mode_out    = mode_q;

endmodule
